bypass_fifo_n: RTL and testbench
================================

# bypass_fifo_n

Parametrised-depth bypass FIFO for inter-rule channels in the multi-cycle library. It generalises the single-entry bypass FIFO to DEPTH entries of WIDTH bits, with an occupancy count output. It keeps the per-round consumed tracking used by the DONE/RESET scheduling handshake. When empty, enqueued data is visible to the consumer in the same cycle.

## Interface
- WIDTH, 8: data bits per entry; legal range ≥1.
- DEPTH, 4: storage entries; legal range ≥1; any value, not only powers of two.
- CLK  in  1  clock; all state updates on its rising edge.
- RST  in  1  synchronous, active-high reset.
- ENQ  in  1  enqueue request, carrying ENQ_VALUE.
- ENQ_VALUE  in  WIDTH  data to enqueue.
- NOT_FULL  out  1  at least one free entry.
- DEQ  in  1  dequeue request.
- DEQ_VALUE  out  WIDTH  head data; the bypassed ENQ_VALUE when the FIFO is empty.
- NOT_EMPTY  out  1  head data valid this cycle.
- COUNT  out  clog2(DEPTH+1)  stored entries; the bypass path is not counted.
- RESET  in  1  round reset; clears the consumed flag.
- CONSUMED  out  1  enqueue accepted this cycle or earlier this round.
- CONSUMED_BEFORE  out  1  enqueue accepted in an earlier cycle of this round.

## Operation
- **State:** storage mem[0..DEPTH-1] (not reset), rd_ptr, wr_ptr, count, consumed.
- **Acceptance:**
  - enq_ok = ENQ && NOT_FULL.
  - deq_ok = DEQ && NOT_EMPTY.
  - ENQ while full is dropped: no state change and no CONSUMED effect. This holds even if DEQ is asserted in the same cycle, because NOT_FULL depends on stored state only.
  - DEQ while not NOT_EMPTY is ignored.
- **Outputs:**
  - NOT_FULL = (count != DEPTH).
  - NOT_EMPTY = (count != 0) || ENQ.
  - DEQ_VALUE = (count == 0) ? ENQ_VALUE : mem[rd_ptr].
- **Empty with enq_ok and deq_ok:** pass-through. No write, pointers and count unchanged.
- **Otherwise:**
  - enq_ok writes mem[wr_ptr] and advances wr_ptr.
  - deq_ok advances rd_ptr.
  - count changes by +1, −1, or 0 when both are accepted.
- **Pointer wrap:** each pointer goes DEPTH-1 → 0.
- **Consumed flag:**
  - next consumed = RESET ? 0 : (enq_ok ? 1 : consumed). RESET has priority over enq_ok.
  - CONSUMED = enq_ok || consumed.
  - CONSUMED_BEFORE = consumed.
- **Reset (RST):**
  - Clears rd_ptr, wr_ptr, count and consumed; mem contents are undefined.
  - Output values during and after reset: NOT_FULL=1, COUNT=0, CONSUMED_BEFORE=0, NOT_EMPTY=ENQ, CONSUMED=ENQ.
  - RST has priority over every other input in that cycle.
  - Reset mid-operation discards all stored entries.

## Timing
- Latency through the empty FIFO with bypass: 0 cycles (combinational ENQ_VALUE → DEQ_VALUE).
- Latency through a non-empty FIFO: the entry reaches the head after all earlier entries are dequeued; at most one dequeue per cycle.
- Throughput: one enqueue and one dequeue per cycle when neither full nor empty.
- Combinational paths:
  - ENQ → NOT_EMPTY, CONSUMED.
  - ENQ_VALUE → DEQ_VALUE.
  - NOT_FULL and COUNT are registered-state functions only.

## Configuration
- **BYPASS_FIFO_N_COMB_BYPASS_EN defined:** behaviour as above.
- **BYPASS_FIFO_N_COMB_BYPASS_EN undefined:** no combinational bypass.
  - NOT_EMPTY = (count != 0); DEQ_VALUE = mem[rd_ptr].
  - ENQ into an empty FIFO is visible one cycle later.
  - Simultaneous ENQ/DEQ when empty: the enqueue is accepted and the DEQ is ignored.
- The consumed logic is identical in both modes.

## Structure
- Shared package bypass_fifo_pkg holds:
  - the clog2 function;
  - the pointer width constant, clog2(max(DEPTH,2));
  - the count width constant, clog2(DEPTH+1).
- One sub-module, bypass_fifo_n_mem: DEPTH×WIDTH register file, one write port, one asynchronous read port, no reset.
- Pointer/count control and consumed logic live in the top level.

## Test plan
1. **Bypass:** DEPTH=4, WIDTH=8. Reset, then ENQ=1 ENQ_VALUE=0x5A DEQ=1 in one cycle → DEQ_VALUE=0x5A, NOT_EMPTY=1, CONSUMED=1; next cycle COUNT=0, CONSUMED_BEFORE=1.
2. **Fill:** enqueue 0x01..0x04 without DEQ → COUNT=4, NOT_FULL=0. A fifth ENQ of 0x05 with DEQ=1 → DEQ_VALUE=0x01, COUNT=3, and 0x05 is never observed.
3. **Wrap:** DEPTH=3. Stream 10 values 0x10..0x19 with ENQ and DEQ both asserted from the second cycle onward → dequeued order 0x10..0x19, COUNT stays at 1.
4. **Round reset:**
   - RESET=1 with ENQ=1 → CONSUMED=1 this cycle; next cycle CONSUMED_BEFORE=0.
   - RESET=1 alone → next cycle CONSUMED_BEFORE=0.
5. **Mid-operation reset:** with COUNT=2, assert RST with ENQ=1 → next cycle COUNT=0, NOT_FULL=1, CONSUMED_BEFORE=0; the dropped entries never appear.
6. **Macro off:** ENQ 0xA5 into an empty FIFO with DEQ=1 → NOT_EMPTY=0 that cycle; next cycle DEQ_VALUE=0xA5, COUNT=1.

Source files
------------

// File: rtl/bypass_fifo_n_pkg.sv
// rtl/bypass_fifo_n_pkg.sv - shared sizing helpers for the bypass FIFO family
package bypass_fifo_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 4;

  // Smallest r with 2**r >= value; clog2(1) == 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

  // Pointers keep at least one bit so DEPTH=1 still has a legal vector.
  function automatic int ptr_width(input int depth);
    return clog2((depth < 2) ? 2 : depth);
  endfunction

  function automatic int count_width(input int depth);
    return clog2(depth + 1);
  endfunction

  localparam int DEFAULT_PTR_W = ptr_width(DEFAULT_DEPTH);
  localparam int DEFAULT_CNT_W = count_width(DEFAULT_DEPTH);

endpackage

// File: rtl/bypass_fifo_n_if.sv
// rtl/bypass_fifo_n_if.sv - enqueue/dequeue/round-handshake bundle of bypass_fifo_n
interface bypass_fifo_n_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  import bypass_fifo_pkg::*;

  localparam int CNT_W = count_width(DEPTH);

  logic             ENQ;
  logic [WIDTH-1:0] ENQ_VALUE;
  logic             NOT_FULL;
  logic             DEQ;
  logic [WIDTH-1:0] DEQ_VALUE;
  logic             NOT_EMPTY;
  logic [CNT_W-1:0] COUNT;
  logic             RESET;
  logic             CONSUMED;
  logic             CONSUMED_BEFORE;

  // Rule side: drives requests and the round reset, observes status.
  modport master (
    output ENQ, ENQ_VALUE, DEQ, RESET,
    input  NOT_FULL, DEQ_VALUE, NOT_EMPTY, COUNT, CONSUMED, CONSUMED_BEFORE
  );

  modport slave (
    input  ENQ, ENQ_VALUE, DEQ, RESET,
    output NOT_FULL, DEQ_VALUE, NOT_EMPTY, COUNT, CONSUMED, CONSUMED_BEFORE
  );

endinterface

// File: rtl/bypass_fifo_n_mem.sv
// rtl/bypass_fifo_n_mem.sv - DEPTH x WIDTH register file, one write port, async read, no reset
module bypass_fifo_n_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             CLK,
  input  logic             wr_en,
  input  logic [PTR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [PTR_W-1:0] rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/bypass_fifo_n.sv
// rtl/bypass_fifo_n.sv - DEPTH-entry bypass FIFO with round consumed tracking
// BYPASS_FIFO_N_COMB_BYPASS_EN: when defined, an empty FIFO forwards ENQ_VALUE to DEQ_VALUE combinationally.
module bypass_fifo_n
  import bypass_fifo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic            CLK,
  input  logic            RST,
  bypass_fifo_n_if.slave  fifo_if
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int CNT_W = count_width(DEPTH);

  localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] COUNT_FULL = CNT_W'(DEPTH);

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             consumed;

  logic             empty;
  logic             not_full;
  logic             not_empty;
  logic             enq_ok;
  logic             deq_ok;
  logic             pass_through;
  logic             do_write;
  logic             do_read;
  logic [WIDTH-1:0] head_value;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_ONE;
  endfunction

  // NOT_FULL looks at stored state only, so a full FIFO drops ENQ even alongside DEQ.
  assign empty    = (count == '0);
  assign not_full = (count != COUNT_FULL);

`ifdef BYPASS_FIFO_N_COMB_BYPASS_EN
  assign not_empty         = !empty || fifo_if.ENQ;
  assign fifo_if.DEQ_VALUE = empty ? fifo_if.ENQ_VALUE : head_value;
  assign pass_through      = empty && enq_ok && deq_ok;
`else
  assign not_empty         = !empty;
  assign fifo_if.DEQ_VALUE = head_value;
  assign pass_through      = 1'b0;
`endif

  assign enq_ok = fifo_if.ENQ && not_full;
  assign deq_ok = fifo_if.DEQ && not_empty;

  // A pass-through transfer never touches storage, pointers or count.
  assign do_write = enq_ok && !pass_through;
  assign do_read  = deq_ok && !pass_through;

  bypass_fifo_n_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_mem (
    .CLK     (CLK),
    .wr_en   (do_write && !RST),
    .wr_addr (wr_ptr),
    .wr_data (fifo_if.ENQ_VALUE),
    .rd_addr (rd_ptr),
    .rd_data (head_value)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_write) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (do_read) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({do_write, do_read})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Round reset wins over an accepted enqueue in the same cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      consumed <= 1'b0;
    end else if (fifo_if.RESET) begin
      consumed <= 1'b0;
    end else if (enq_ok) begin
      consumed <= 1'b1;
    end
  end

  assign fifo_if.NOT_FULL        = not_full;
  assign fifo_if.NOT_EMPTY       = not_empty;
  assign fifo_if.COUNT           = count;
  assign fifo_if.CONSUMED        = enq_ok || consumed;
  assign fifo_if.CONSUMED_BEFORE = consumed;

endmodule

// File: tb/tb_bypass_fifo_n.sv
// tb/tb_bypass_fifo_n.sv - directed table-driven bench for bypass_fifo_n (DEPTH=4 and DEPTH=3)
module tb_bypass_fifo_n;

`ifdef BYPASS_FIFO_N_COMB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    logic       rst;
    logic       enq;
    logic [7:0] ev;
    logic       deq;
    logic       rres;
    logic       nf;
    logic       ne;
    logic [7:0] dv;
    logic       dv_chk;
    logic [2:0] cnt;
    logic       cons;
    logic       cb;
  } vec_t;

  logic CLK;
  logic RST;
  int   n_cmp;
  int   n_bad;

  bypass_fifo_n_if #(.WIDTH(8), .DEPTH(4)) if4 ();
  bypass_fifo_n_if #(.WIDTH(8), .DEPTH(3)) if3 ();

  bypass_fifo_n #(.WIDTH(8), .DEPTH(4)) u4 (.CLK(CLK), .RST(RST), .fifo_if(if4));
  bypass_fifo_n #(.WIDTH(8), .DEPTH(3)) u3 (.CLK(CLK), .RST(RST), .fifo_if(if3));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  vec_t vecs [20];

  initial begin
    n_cmp = 0;
    n_bad = 0;

    //            rst  enq ev      deq  rres  nf   ne    dv      chk   cnt                cons cb
    vecs[0]  = '{1'b1, 1'b1, 8'h77, 1'b0, 1'b0, 1'b1, BYP,  8'h77, BYP,  3'd0,              1'b1, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0,              1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 1'b1, BYP,  8'h01, BYP,  3'd0,              1'b1, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 8'h02, 1'b0, 1'b0, 1'b1, 1'b1, 8'h01, 1'b1, 3'd1,              1'b1, 1'b1};
    vecs[4]  = '{1'b0, 1'b1, 8'h03, 1'b0, 1'b0, 1'b1, 1'b1, 8'h01, 1'b1, 3'd2,              1'b1, 1'b1};
    vecs[5]  = '{1'b0, 1'b1, 8'h04, 1'b0, 1'b0, 1'b1, 1'b1, 8'h01, 1'b1, 3'd3,              1'b1, 1'b1};
    vecs[6]  = '{1'b0, 1'b1, 8'h05, 1'b1, 1'b0, 1'b0, 1'b1, 8'h01, 1'b1, 3'd4,              1'b1, 1'b1};
    vecs[7]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h02, 1'b1, 3'd3,              1'b1, 1'b1};
    vecs[8]  = '{1'b0, 1'b1, 8'h06, 1'b1, 1'b1, 1'b1, 1'b1, 8'h02, 1'b1, 3'd3,              1'b1, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h03, 1'b1, 3'd3,              1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'h04, 1'b1, 3'd2,              1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 8'h07, 1'b1, 1'b0, 1'b1, 1'b1, 8'h04, 1'b1, 3'd2,              1'b1, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'h06, 1'b1, 3'd2,              1'b1, 1'b1};
    vecs[13] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h06, 1'b1, 3'd2,              1'b0, 1'b0};
    vecs[14] = '{1'b1, 1'b1, 8'h08, 1'b0, 1'b0, 1'b1, 1'b1, 8'h06, 1'b1, 3'd2,              1'b1, 1'b0};
    vecs[15] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0,              1'b0, 1'b0};
    vecs[16] = '{1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b1, BYP,  8'hA5, BYP,  3'd0,              1'b1, 1'b0};
    vecs[17] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, !BYP, 8'hA5, !BYP, BYP ? 3'd0 : 3'd1, 1'b1, 1'b1};
    vecs[18] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, !BYP, 8'hA5, !BYP, BYP ? 3'd0 : 3'd1, 1'b1, 1'b1};
    vecs[19] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0,              1'b1, 1'b1};

    RST           = 1'b1;
    if4.ENQ       = 1'b0;
    if4.ENQ_VALUE = 8'h00;
    if4.DEQ       = 1'b0;
    if4.RESET     = 1'b0;
    if3.ENQ       = 1'b0;
    if3.ENQ_VALUE = 8'h00;
    if3.DEQ       = 1'b0;
    if3.RESET     = 1'b0;
    repeat (2) @(posedge CLK);

    for (int i = 0; i < 20; i++) begin
      #1;
      RST           = vecs[i].rst;
      if4.ENQ       = vecs[i].enq;
      if4.ENQ_VALUE = vecs[i].ev;
      if4.DEQ       = vecs[i].deq;
      if4.RESET     = vecs[i].rres;
      @(negedge CLK);
      check($sformatf("r%0d_not_full", i), 32'(if4.NOT_FULL), 32'(vecs[i].nf));
      check($sformatf("r%0d_not_empty", i), 32'(if4.NOT_EMPTY), 32'(vecs[i].ne));
      check($sformatf("r%0d_count", i), 32'(if4.COUNT), 32'(vecs[i].cnt));
      check($sformatf("r%0d_consumed", i), 32'(if4.CONSUMED), 32'(vecs[i].cons));
      check($sformatf("r%0d_consumed_before", i), 32'(if4.CONSUMED_BEFORE), 32'(vecs[i].cb));
      if (vecs[i].dv_chk) begin
        check($sformatf("r%0d_deq_value", i), 32'(if4.DEQ_VALUE), 32'(vecs[i].dv));
      end
      @(posedge CLK);
    end

    #1;
    RST           = 1'b0;
    if4.ENQ       = 1'b0;
    if4.DEQ       = 1'b0;
    if4.RESET     = 1'b0;

    // DEPTH=3 streaming: one entry in flight, pointers wrap several times.
    for (int k = 0; k <= 10; k++) begin
      if3.ENQ       = (k < 10);
      if3.ENQ_VALUE = 8'h10 + 8'(k);
      if3.DEQ       = (k > 0);
      @(negedge CLK);
      if (k > 0) begin
        check($sformatf("wrap%0d_deq_value", k), 32'(if3.DEQ_VALUE), 32'(8'h10 + 8'(k - 1)));
        check($sformatf("wrap%0d_count", k), 32'(if3.COUNT), 32'd1);
        check($sformatf("wrap%0d_not_full", k), 32'(if3.NOT_FULL), 32'd1);
      end
      @(posedge CLK);
      #1;
    end
    if3.ENQ = 1'b0;
    if3.DEQ = 1'b0;
    @(negedge CLK);
    check("wrap_end_count", 32'(if3.COUNT), 32'd0);
    check("wrap_end_not_empty", 32'(if3.NOT_EMPTY), 32'd0);

    // DEPTH=3 fill to full, then a dropped ENQ alongside DEQ.
    for (int k = 0; k < 3; k++) begin
      @(posedge CLK);
      #1;
      if3.ENQ       = 1'b1;
      if3.ENQ_VALUE = 8'hC0 + 8'(k);
    end
    @(posedge CLK);
    #1;
    if3.ENQ       = 1'b1;
    if3.ENQ_VALUE = 8'hEE;
    if3.DEQ       = 1'b1;
    @(negedge CLK);
    check("full3_not_full", 32'(if3.NOT_FULL), 32'd0);
    check("full3_count", 32'(if3.COUNT), 32'd3);
    check("full3_head", 32'(if3.DEQ_VALUE), 32'hC0);
    @(posedge CLK);
    #1;
    if3.ENQ = 1'b0;
    for (int k = 1; k < 3; k++) begin
      @(negedge CLK);
      check($sformatf("drain3_%0d_value", k), 32'(if3.DEQ_VALUE), 32'(8'hC0 + 8'(k)));
      @(posedge CLK);
      #1;
    end
    @(negedge CLK);
    check("drain3_empty_count", 32'(if3.COUNT), 32'd0);
    check("drain3_not_empty", 32'(if3.NOT_EMPTY), 32'd0);
    if3.DEQ = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
